sink_arbiter_rr: RTL and testbench

- Registered, parametrised successor to the combinational sink-index encoder.
- Selects one of NUM_SINKS requesting sinks and holds the grant until the downstream accepts it.
- Runtime mode is either fixed priority (lowest index wins, same ordering as the legacy encoder) or round-robin.
- Sits between per-sink valid flags and the shared interconnect output mux; grant_idx drives the mux select.

---
 rtl/sink_arb_pkg.sv | 12 +
 rtl/rr_prio_pick.sv | 50 +++++
 rtl/sink_arbiter_rr.sv | 124 ++++++++++++
 tb/tb_sink_arbiter_rr.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sink_arb_pkg.sv
// Shared definitions for the sink arbiter: default sizing and FSM encoding.
package sink_arb_pkg;

    localparam int SINK_ARB_NUM_SINKS      = 8;
    localparam int SINK_ARB_LOG2_NUM_SINKS = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational winner search over the sink requests.
// Fixed mode returns the lowest set index. RR mode returns the first set bit
// at or after ptr, wrapping through index 0. The search runs over the request
// vector doubled: the lower copy keeps only bits at or above ptr, and the upper
// copy keeps every bit. The lowest hit in this doubled vector, folded back by
// NUM_SINKS, is the round-robin winner.
module rr_prio_pick #(
    parameter int NUM_SINKS      = 8,
    parameter int LOG2_NUM_SINKS = 3
) (
    input  logic [NUM_SINKS-1:0]      valids,
    input  logic [LOG2_NUM_SINKS-1:0] ptr,
    input  logic                      rr_mode,
    output logic [LOG2_NUM_SINKS-1:0] pick_idx,
    output logic                      pick_found
);

    localparam int PW = LOG2_NUM_SINKS + 1;

    logic [NUM_SINKS-1:0]   w_mask;
    logic [2*NUM_SINKS-1:0] w_dbl;
    logic [PW-1:0]          w_pos;
    logic                   w_hit;

    // Lower-copy mask: in RR mode keep bits at or above ptr. In fixed mode keep every bit.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NUM_SINKS; i++) begin
            w_mask[i] = !rr_mode || (i >= int'(ptr));
        end
    end

    assign w_dbl = {valids, valids & w_mask};

    // Lowest-set-bit search over the doubled vector, ascending index.
    always_comb begin
        w_hit = 1'b0;
        w_pos = '0;
        for (int i = 0; i < 2*NUM_SINKS; i++) begin
            if (!w_hit && w_dbl[i]) begin
                w_hit = 1'b1;
                w_pos = PW'(i);
            end
        end
    end

    assign pick_found = w_hit;
    assign pick_idx   = LOG2_NUM_SINKS'((w_pos >= PW'(NUM_SINKS)) ? (w_pos - PW'(NUM_SINKS)) : w_pos);

endmodule

// File: rtl/sink_arbiter_rr.sv
// Registered sink arbiter with a fixed-priority mode and a round-robin mode.
// The arbiter holds each grant until the downstream accepts it. grant_idx
// drives the select input of the interconnect output mux.
// Optional build macro ARB_PKT_LOCK_EN: the grant is locked for a whole packet.
// The lock is released only when an accept arrives with last=1.
module sink_arbiter_rr
    import sink_arb_pkg::*;
#(
    parameter int NUM_SINKS      = SINK_ARB_NUM_SINKS,
    parameter int LOG2_NUM_SINKS = SINK_ARB_LOG2_NUM_SINKS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SINKS-1:0]      valids,
    input  logic                      ready,
    input  logic                      rr_mode,
    input  logic                      last,
    output logic                      grant_valid,
    output logic [LOG2_NUM_SINKS-1:0] grant_idx,
    output logic [NUM_SINKS-1:0]      grant_onehot
);

    arb_state_e                r_state, w_state_nxt;
    logic [LOG2_NUM_SINKS-1:0] r_ptr, w_ptr_nxt;
    logic [LOG2_NUM_SINKS-1:0] r_grant_idx, w_idx_nxt;
    logic                      r_grant_valid, w_gv_nxt;
    logic [NUM_SINKS-1:0]      r_grant_onehot, w_oh_nxt;

    logic                      w_accept;
    logic                      w_withdrawn;
    logic                      w_release;
    logic                      w_reopen;
    logic                      w_adv_ptr;
    logic                      w_arb;
    logic [LOG2_NUM_SINKS-1:0] w_ptr_inc;
    logic [LOG2_NUM_SINKS-1:0] w_pick_ptr;
    logic [LOG2_NUM_SINKS-1:0] w_pick_idx;
    logic                      w_pick_found;

    assign w_accept    = r_grant_valid & ready;
    // The one-hot register avoids indexing valids with a possibly wide index.
    assign w_withdrawn = ~|(valids & r_grant_onehot);

`ifdef ARB_PKT_LOCK_EN
    // Only the final beat of a packet ends the grant. Withdrawal does not release the lock.
    assign w_release = w_accept & last;
    assign w_reopen  = 1'b0;
`else
    logic w_unused_last;
    assign w_unused_last = last;
    assign w_release     = w_accept;
    assign w_reopen      = ~ready & w_withdrawn;
`endif

    // Explicit wrap so that sink counts that are not a power of 2 cycle correctly.
    assign w_ptr_inc  = (r_grant_idx == LOG2_NUM_SINKS'(NUM_SINKS - 1)) ? '0
                                                                         : r_grant_idx + LOG2_NUM_SINKS'(1);
    assign w_adv_ptr  = w_release & rr_mode;
    // When a re-arbitration follows an accept, it uses the pointer that has just been advanced.
    assign w_pick_ptr = w_adv_ptr ? w_ptr_inc : r_ptr;

    rr_prio_pick #(
        .NUM_SINKS      (NUM_SINKS),
        .LOG2_NUM_SINKS (LOG2_NUM_SINKS)
    ) u_pick (
        .valids     (valids),
        .ptr        (w_pick_ptr),
        .rr_mode    (rr_mode),
        .pick_idx   (w_pick_idx),
        .pick_found (w_pick_found)
    );

    // Next-state logic: decide when to arbitrate and load the winner or fall back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_idx_nxt   = r_grant_idx;
        w_gv_nxt    = r_grant_valid;
        w_oh_nxt    = r_grant_onehot;
        w_arb       = 1'b0;
        case (r_state)
            IDLE:  w_arb = 1'b1;
            GRANT: begin
                if (w_adv_ptr) w_ptr_nxt = w_ptr_inc;
                w_arb = w_release | w_reopen;
            end
            default: w_arb = 1'b1;
        endcase
        if (w_arb) begin
            if (w_pick_found) begin
                w_state_nxt = GRANT;
                w_gv_nxt    = 1'b1;
                w_idx_nxt   = w_pick_idx;
                w_oh_nxt    = NUM_SINKS'(1) << w_pick_idx;
            end else begin
                w_state_nxt = IDLE;
                w_gv_nxt    = 1'b0;
                w_oh_nxt    = '0;
            end
        end
    end

    // State, pointer and output registers. The reset clears them asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_ptr          <= '0;
            r_grant_idx    <= '0;
            r_grant_valid  <= 1'b0;
            r_grant_onehot <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_ptr          <= w_ptr_nxt;
            r_grant_idx    <= w_idx_nxt;
            r_grant_valid  <= w_gv_nxt;
            r_grant_onehot <= w_oh_nxt;
        end
    end

    assign grant_valid  = r_grant_valid;
    assign grant_idx    = r_grant_idx;
    assign grant_onehot = r_grant_onehot;

endmodule

// File: tb/tb_sink_arbiter_rr.sv
// Bench for sink_arbiter_rr. Two instances (8 sinks and 5 sinks) share the same stimulus.
// A reference model computes the expected grant from the arbitration rules.
module tb_sink_arbiter_rr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] valids;
    logic       ready, rr_mode, last;

    logic       gv8, gv5;
    logic [2:0] idx8, idx5;
    logic [7:0] oh8;
    logic [4:0] oh5;

    int ncmp  = 0;
    int nfail = 0;

    bit mgv  [2];
    int midx [2];
    int mptr [2];

    always #5 clk = ~clk;

    sink_arbiter_rr #(.NUM_SINKS(8), .LOG2_NUM_SINKS(3)) dut8 (
        .clk(clk), .rst_n(rst_n), .valids(valids), .ready(ready), .rr_mode(rr_mode),
        .last(last), .grant_valid(gv8), .grant_idx(idx8), .grant_onehot(oh8));

    sink_arbiter_rr #(.NUM_SINKS(5), .LOG2_NUM_SINKS(3)) dut5 (
        .clk(clk), .rst_n(rst_n), .valids(valids[4:0]), .ready(ready), .rr_mode(rr_mode),
        .last(last), .grant_valid(gv5), .grant_idx(idx5), .grant_onehot(oh5));

    function automatic int nsinks(int d);
        return (d == 0) ? 8 : 5;
    endfunction

    // Return the first requesting sink in search order: from 0 in fixed mode, from ptr (wrapping) in RR mode.
    function automatic void mpick(int n, logic [7:0] v, int ptr, bit rr, output bit f, output int w);
        int j;
        f = 0;
        w = 0;
        for (int k = 0; k < n; k++) begin
            j = rr ? (ptr + k) % n : k;
            if (!f && v[j]) begin
                f = 1;
                w = j;
            end
        end
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mgv[d]  = 0;
            midx[d] = 0;
            mptr[d] = 0;
        end
    endtask

    // Compute the state after the next clock edge from the inputs applied now.
    task automatic model_step();
        bit f, rel, reopen;
        int w, n;
        for (int d = 0; d < 2; d++) begin
            n = nsinks(d);
            if (!mgv[d]) begin
                mpick(n, valids, mptr[d], rr_mode, f, w);
                if (f) begin
                    mgv[d]  = 1;
                    midx[d] = w;
                end
            end else begin
`ifdef ARB_PKT_LOCK_EN
                rel    = ready && last;
                reopen = 0;
`else
                rel    = ready;
                reopen = !ready && !valids[midx[d]];
`endif
                if (rel && rr_mode) mptr[d] = (midx[d] + 1) % n;
                if (rel || reopen) begin
                    mpick(n, valids, mptr[d], rr_mode, f, w);
                    if (f) midx[d] = w;
                    else   mgv[d]  = 0;
                end
            end
        end
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, "/gv8"},  64'(gv8),  64'(mgv[0]));
        chk({tag, "/idx8"}, 64'(idx8), 64'(midx[0]));
        chk({tag, "/oh8"},  64'(oh8),  mgv[0] ? (64'd1 << midx[0]) : 64'd0);
        chk({tag, "/gv5"},  64'(gv5),  64'(mgv[1]));
        chk({tag, "/idx5"}, 64'(idx5), 64'(midx[1]));
        chk({tag, "/oh5"},  64'(oh5),  mgv[1] ? (64'd1 << midx[1]) : 64'd0);
    endtask

    task automatic tick(string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Assert reset partway through a cycle: the outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        valids  = 8'hFF;
        ready   = 1'b0;
        rr_mode = 1'b0;
        last    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_hold");
        rst_n = 1'b1;
        tick("reset_release");

        // Fixed priority: the lowest index keeps winning; dropping it hands the grant to the next one up.
        valids = 8'b1010_0100;
        ready  = 1'b1;
        repeat (3) tick("fixed_lowest");
        valids = 8'b1010_0000;
        tick("fixed_drop");

        // Round-robin over all requesters, starting from a fresh pointer.
        rr_mode = 1'b1;
        valids  = 8'hFF;
        do_reset();
        repeat (10) tick("rr_sweep");

        // Stall holds the grant; withdrawing it re-arbitrates.
        rr_mode = 1'b0;
        valids  = 8'h00;
        repeat (2) tick("drain");
        valids = 8'h08;
        tick("grant3");
        ready = 1'b0;
        tick("stall");
        valids = 8'h09;
        repeat (3) tick("stall_hold");
        valids = 8'h01;
        tick("withdraw");

        // A single request, accepted with no further requests, returns the arbiter to idle.
        valids = 8'h00;
        ready  = 1'b1;
        repeat (2) tick("drain2");
        valids = 8'h40;
        tick("grant6");
        valids = 8'h00;
        tick("accept_empty");
        tick("idle_after");

        // Reset in the middle of a grant; the first grant after release uses ptr=0.
        rr_mode = 1'b1;
        valids  = 8'hFF;
        repeat (3) tick("pre_rst");
        do_reset();
        tick("post_rst");

`ifdef ARB_PKT_LOCK_EN
        do_reset();
        ready  = 1'b0;
        valids = 8'h02;
        tick("lock_grant1");
        valids = 8'h12;
        ready  = 1'b1;
        last   = 1'b0;
        repeat (2) tick("lock_beat");
        last = 1'b1;
        tick("lock_last");
        last = 1'b0;
`endif

        // Randomized traffic, with an occasional asynchronous reset.
        for (int i = 0; i < 400; i++) begin
            valids  = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
            ready   = ($urandom_range(0, 3) != 0);
            rr_mode = ($urandom_range(0, 3) != 0);
            last    = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) == 0) do_reset();
            tick("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
